// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef enum logic {
    WR_PORT0 = 1'b0,
    WR_PORT1 = 1'b1
  } wr_port_e;

  // Port that owns the data when both write ports hit the same register.
  localparam wr_port_e WR_PRIO_PORT = WR_PORT1;

  function automatic logic zero_masked(input int zero_reg, input logic addr_is_zero);
    return (zero_reg != 0) && addr_is_zero;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address mux, zero-register mask, busy lookup,
// and the same-cycle write bypass when REGFILE_BYPASS_EN is defined.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   busy_vec,
`ifdef REGFILE_BYPASS_EN
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic [DATA_W-1:0]      wr0_data,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_addr,
  input  logic [DATA_W-1:0]      wr1_data,
`endif
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_busy
);

`ifdef REGFILE_BYPASS_EN
  logic              hi_hit;
  logic              lo_hit;
  logic [DATA_W-1:0] hi_data;
  logic [DATA_W-1:0] lo_data;

  assign hi_hit  = (WR_PRIO_PORT == WR_PORT1) ? (wr1_en && (wr1_addr == rd_addr))
                                              : (wr0_en && (wr0_addr == rd_addr));
  assign lo_hit  = (WR_PRIO_PORT == WR_PORT1) ? (wr0_en && (wr0_addr == rd_addr))
                                              : (wr1_en && (wr1_addr == rd_addr));
  assign hi_data = (WR_PRIO_PORT == WR_PORT1) ? wr1_data : wr0_data;
  assign lo_data = (WR_PRIO_PORT == WR_PORT1) ? wr0_data : wr1_data;
`endif

  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy_vec[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (hi_hit) begin
      rd_data = hi_data;
      rd_busy = 1'b0;
    end else if (lo_hit) begin
      rd_data = lo_data;
      rd_busy = 1'b0;
    end else begin
    end
`endif
    // Zero masking wins over bypass so a write to R0 never leaks through.
    if (zero_masked(ZERO_REG, rd_addr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else begin
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised 2R/2W register file with claim/release busy scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic                   rd_busy_a,
  output logic                   rd_busy_b,
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic [DATA_W-1:0]      wr0_data,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_addr,
  input  logic [DATA_W-1:0]      wr1_data,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic                   claim_ok,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic              lo_en;
  logic              hi_en;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic [DATA_W-1:0] lo_data;
  logic [DATA_W-1:0] hi_data;

  // Claim acceptance looks only at registered busy state, never at writes.
  assign claim_ok = claim_en & ~busy_q[claim_addr];
  assign busy_vec = busy_q;

  assign lo_en   = (WR_PRIO_PORT == WR_PORT1) ? wr0_en   : wr1_en;
  assign lo_addr = (WR_PRIO_PORT == WR_PORT1) ? wr0_addr : wr1_addr;
  assign lo_data = (WR_PRIO_PORT == WR_PORT1) ? wr0_data : wr1_data;
  assign hi_en   = (WR_PRIO_PORT == WR_PORT1) ? wr1_en   : wr0_en;
  assign hi_addr = (WR_PRIO_PORT == WR_PORT1) ? wr1_addr : wr0_addr;
  assign hi_data = (WR_PRIO_PORT == WR_PORT1) ? wr1_data : wr0_data;

  // Low-priority write first, high-priority overwrites, claim sets busy last.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (lo_en && !zero_masked(ZERO_REG, lo_addr == '0)) begin
      regs_d[lo_addr] = lo_data;
      busy_d[lo_addr] = 1'b0;
    end else begin
    end
    if (hi_en && !zero_masked(ZERO_REG, hi_addr == '0)) begin
      regs_d[hi_addr] = hi_data;
      busy_d[hi_addr] = 1'b0;
    end else begin
    end
    if (claim_ok && !zero_masked(ZERO_REG, claim_addr == '0)) begin
      busy_d[claim_addr] = 1'b1;
    end else begin
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_read_a (
    .rd_addr  (rd_addr_a),
    .regs     (regs_q),
    .busy_vec (busy_q),
`ifdef REGFILE_BYPASS_EN
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
`endif
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a)
  );

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_read_b (
    .rd_addr  (rd_addr_b),
    .regs     (regs_q),
    .busy_vec (busy_q),
`ifdef REGFILE_BYPASS_EN
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
`endif
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus random bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        wr0_en, wr1_en;
  logic [3:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic        claim_ok;
  logic [15:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [16];
  bit          m_busy [16];

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [15:0] exp_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic exp_claim_ok();
    return claim_en && !m_busy[claim_addr];
  endfunction

  // Edge semantics: writes (port 1 last so it wins), then an accepted claim re-marks busy.
  task automatic model_edge();
    bit accept;
    accept = exp_claim_ok();
    if (wr0_en && wr0_addr != 4'd0) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
    if (wr1_en && wr1_addr != 4'd0) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
    if (accept && claim_addr != 4'd0) m_busy[claim_addr] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_data_a"}, rd_data_a, exp_data(rd_addr_a));
    chk({tag, ".rd_data_b"}, rd_data_b, exp_data(rd_addr_b));
    chk({tag, ".rd_busy_a"}, rd_busy_a, exp_busy(rd_addr_a));
    chk({tag, ".rd_busy_b"}, rd_busy_b, exp_busy(rd_addr_b));
    chk({tag, ".claim_ok"},  claim_ok,  exp_claim_ok());
    chk({tag, ".busy_vec"},  busy_vec,  exp_busy_vec());
  endtask

  // Inputs are set mid-cycle; check settles 1 time unit later, then the edge is taken.
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = 4'd0; wr0_data = 32'h0;
    wr1_en = 1'b0; wr1_addr = 4'd0; wr1_data = 32'h0;
    claim_en = 1'b0; claim_addr = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd0;
    idle();
    model_reset();

    // Reset state, all addresses on both ports.
    #2;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      chk("rst_rd_a", rd_data_a, 32'h0);
      chk("rst_rd_b", rd_data_b, 32'h0);
    end
    chk("rst_busy_vec", busy_vec, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      #1;
      chk("post_rst_rd_a", rd_data_a, 32'h0);
      chk("post_rst_busy_a", rd_busy_a, 1'b0);
    end
    chk("post_rst_busy_vec", busy_vec, 16'h0000);
    @(posedge clk);
    #1;

    // Basic write then read.
    wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'hDEADBEEF; rd_addr_a = 4'd5;
    tick("wr_r5");
    idle();
    #1 chk("rd_r5", rd_data_a, 32'hDEADBEEF);
    tick("rd_r5_cyc");

    // Same-address collision, then R0 write discard.
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h1111;
    wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 32'h2222;
    tick("collide");
    idle();
    wr1_en = 1'b1; wr1_addr = 4'd0; wr1_data = 32'hFFFF_FFFF; rd_addr_a = 4'd3;
    #1 chk("collide_r3", rd_data_a, 32'h2222);
    tick("wr_r0");
    idle();
    rd_addr_a = 4'd0;
    #1 chk("r0_zero", rd_data_a, 32'h0);
    tick("r0_cyc");

    // Scoreboard round trip on R7.
    claim_en = 1'b1; claim_addr = 4'd7; rd_addr_b = 4'd7;
    #1 chk("claim7_ok", claim_ok, 1'b1);
    tick("claim7");
    #1 chk("busy7_set", busy_vec[7], 1'b1);
    chk("claim7_refused", claim_ok, 1'b0);
    chk("rd_busy_b7", rd_busy_b, 1'b1);
    tick("claim7_retry");
    idle();
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h0000_00A5;
    tick("wr7");
    idle();
    claim_en = 1'b1; claim_addr = 4'd7; rd_addr_a = 4'd7;
    #1 chk("busy7_clear", busy_vec[7], 1'b0);
    chk("claim7_again", claim_ok, 1'b1);
    chk("rd_r7", rd_data_a, 32'h0000_00A5);
    tick("claim7_again_cyc");
    idle();

    // Claim and write to R9 on the same edge.
    claim_en = 1'b1; claim_addr = 4'd9;
    wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 32'h0000_0099;
    tick("claim_wr9");
    idle();
    rd_addr_a = 4'd9;
    #1 chk("r9_data", rd_data_a, 32'h0000_0099);
    chk("r9_busy", busy_vec[9], 1'b1);
    tick("r9_cyc");

    // Claim of R0 is accepted but leaves no trace.
    claim_en = 1'b1; claim_addr = 4'd0;
    #1 chk("claim0_ok", claim_ok, 1'b1);
    tick("claim0");
    idle();
    #1 chk("busy0_clear", busy_vec[0], 1'b0);

    // Asynchronous reset pulse between edges.
    wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h55;
    claim_en = 1'b1; claim_addr = 4'd4;
    tick("pre_rst");
    idle();
    rd_addr_a = 4'd2; rd_addr_b = 4'd4;
    #1 chk("pre_rst_r2", rd_data_a, 32'h55);
    chk("pre_rst_busy4", rd_busy_b, 1'b1);
    rst_n = 1'b0;
    #1 chk("arst_r2", rd_data_a, 32'h0);
    chk("arst_busy4", rd_busy_b, 1'b0);
    chk("arst_busy_vec", busy_vec, 16'h0000);
    rst_n = 1'b1;
    model_reset();
    tick("after_arst");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rd_addr_a  = 4'($urandom_range(0, 15));
      rd_addr_b  = 4'($urandom_range(0, 15));
      wr0_en     = ($urandom_range(0, 2) == 0);
      wr0_addr   = 4'($urandom_range(0, 15));
      wr0_data   = $urandom;
      wr1_en     = ($urandom_range(0, 3) == 0);
      wr1_addr   = ($urandom_range(0, 3) == 0) ? wr0_addr : 4'($urandom_range(0, 15));
      wr1_data   = $urandom;
      claim_en   = ($urandom_range(0, 1) == 0);
      claim_addr = 4'($urandom_range(0, 15));
      tick("rand");
    end
    idle();
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
